apb_multi_slave_bridge: RTL and testbench
=========================================

// Module: apb_multi_slave_bridge
// PURPOSE
//  Parametrised APB master bridge. Drives NUM_SLV APB slaves from one request interface, using an
//  IDLE/SETUP/ACCESS FSM. Decodes the slave from the upper PADDR bits and returns registered read data.
//  Reports error (PSLVERR) for unmapped addresses and slave errors. Sits between the test/system
//  request side and the slave array, as the next-generation replacement of the 2-slave top level.
// PARAMETERS
//  ADDR_W   9   total address width; upper SEL_W bits select the slave, the rest are slave-local
//  DATA_W   8   PWDATA/PRDATA width
//  NUM_SLV  2   number of slaves (>=1); SEL_W = (NUM_SLV>1) ? $clog2(NUM_SLV) : 1
//  TIMEOUT  16  max ACCESS wait cycles; used only with APB_TIMEOUT_EN (>=1)
// PORTS
//  PCLK              in   1               clock; all logic on rising edge
//  PRESET            in   1               synchronous reset, active-high
//  transfer          in   1               request valid; sampled in IDLE or on the completing ACCESS cycle
//  READ_WRITE        in   1               1=read, 0=write; sampled with transfer
//  apb_write_paddr   in   ADDR_W          write address
//  apb_write_data    in   DATA_W          write data
//  apb_read_paddr    in   ADDR_W          read address
//  apb_read_data_out out  DATA_W          data of last completed good read (registered)
//  PSLVERR           out  1               1-cycle error pulse, coincident with xfer_done
//  xfer_done         out  1               1-cycle pulse: transfer completed (good or error)
//  PSEL              out  NUM_SLV         one-hot slave select
//  PENABLE           out  1               APB access phase
//  PWRITE            out  1               APB direction
//  PADDR             out  ADDR_W          APB address (full width; slaves use low ADDR_W-SEL_W bits)
//  PWDATA            out  DATA_W          APB write data
//  PRDATA            in   NUM_SLV*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
//  PREADY            in   NUM_SLV         per-slave ready
//  PSLVERR_S         in   NUM_SLV         per-slave error
// BEHAVIOUR
//  - Reset: state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0,
//    apb_read_data_out=0, PSLVERR=0, xfer_done=0. Reset dominates any in-flight transfer;
//    the transfer is dropped with no xfer_done.
//  - IDLE: transfer=1 -> latch PWRITE=~READ_WRITE, PADDR=read/write paddr, PWDATA; go to SETUP.
//    idx = PADDR[ADDR_W-1 -: SEL_W].
//  - SETUP (1 cycle): PSEL[idx]=1, PENABLE=0; go to ACCESS.
//    If idx>=NUM_SLV: no PSEL asserted, skip ACCESS, pulse xfer_done+PSLVERR, return to IDLE.
//  - ACCESS: PSEL[idx]=1, PENABLE=1; hold all outputs stable while PREADY[idx]=0.
//    On PREADY[idx]=1: xfer_done=1; PSLVERR=PSLVERR_S[idx];
//    on a read with no error, apb_read_data_out<=PRDATA slice idx.
//  - Back-to-back: transfer=1 on the completing ACCESS cycle -> latch the new request and go straight
//    to SETUP (PSEL may stay high, PENABLE drops). Otherwise -> IDLE, PSEL=0.
//  - Minimum latency: transfer sampled at edge N; SETUP in N..N+1; ACCESS from N+1;
//    xfer_done at edge N+2 when PREADY=1 with zero wait states.
//  - PREADY/PRDATA/PSLVERR_S of unselected slaves are ignored. transfer is ignored in SETUP and in
//    wait-state ACCESS cycles.
//  - Error reads never update apb_read_data_out.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: wait counter cleared on entry to ACCESS, incremented on each PREADY=0
//    cycle. When it reaches TIMEOUT: abort with xfer_done=1, PSLVERR=1, PSEL/PENABLE deasserted, go to
//    IDLE (the back-to-back rule does not apply).
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for PREADY.
// STRUCTURE
//  Package apb_bridge_pkg: state enum {IDLE,SETUP,ACCESS}; sel_width function ($clog2 guard);
//    APB_READ/APB_WRITE constants.
//  Sub-module apb_addr_decoder: PADDR -> one-hot PSEL vector + addr_err flag (combinational).
//  Top: FSM, request latch, read-data mux/register, timeout counter.
// TESTING
//  1 Write idx0, zero wait: addr 0x005, data 0xA5 -> PSEL=01 SETUP then ACCESS; PWDATA=0xA5;
//    xfer_done at cycle 2; PSLVERR=0.
//  2 Read idx1, 3 wait states: addr 0x10F, slave1 PRDATA=0x3C -> PENABLE held 4 cycles;
//    apb_read_data_out=0x3C after done.
//  3 NUM_SLV=3, ADDR_W=9, addr 0x1C0 (idx3) -> no PSEL, xfer_done+PSLVERR one cycle after SETUP;
//    read data unchanged.
//  4 Back-to-back write 0x001 then read 0x101 with transfer held -> ACCESS->SETUP direct;
//    2 xfer_done pulses 2 cycles apart.
//  5 PSLVERR_S[0]=1 on read completion -> PSLVERR=1, apb_read_data_out keeps prior value.
//  6 PRESET=1 mid-ACCESS (or APB_TIMEOUT_EN, TIMEOUT=4, PREADY=0) -> outputs reset, no done /
//    abort at wait 4 with PSLVERR=1.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types and helpers for the multi-slave APB bridge
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic APB_READ  = 1'b1;
  localparam logic APB_WRITE = 1'b0;

  // A single slave still needs one select bit so the address slice stays legal.
  function automatic int sel_width(input int num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - slave-index field to one-hot PSEL plus unmapped-address flag
module apb_addr_decoder
  import apb_bridge_pkg::*;
#(
  parameter int NUM_SLV = 2,
  parameter int SEL_W   = sel_width(NUM_SLV)
) (
  input  logic [SEL_W-1:0]   idx,
  output logic [NUM_SLV-1:0] sel,
  output logic               addr_err
);

  always_comb begin
    sel      = '0;
    addr_err = 1'b1;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == SEL_W'(i)) begin
        sel[i]   = 1'b1;
        addr_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_multi_slave_bridge.sv
// rtl/apb_multi_slave_bridge.sv - APB master bridge driving NUM_SLV slaves via IDLE/SETUP/ACCESS
// Optional wait-state abort enabled by defining APB_TIMEOUT_EN.
module apb_multi_slave_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      transfer,
  input  logic                      READ_WRITE,
  input  logic [ADDR_W-1:0]         apb_write_paddr,
  input  logic [DATA_W-1:0]         apb_write_data,
  input  logic [ADDR_W-1:0]         apb_read_paddr,
  output logic [DATA_W-1:0]         apb_read_data_out,
  output logic                      PSLVERR,
  output logic                      xfer_done,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR_S
);

  localparam int SEL_W = sel_width(NUM_SLV);

  state_t              state;
  logic                addr_err_q;
  logic [ADDR_W-1:0]   req_addr;
  logic [NUM_SLV-1:0]  req_sel;
  logic                req_err;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic                timeout_hit;
  logic                accept;

  assign req_addr = (READ_WRITE == APB_READ) ? apb_read_paddr : apb_write_paddr;

  // Decode the incoming request so PSEL is valid in the very first SETUP cycle.
  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_dec (
    .idx      (req_addr[ADDR_W-1 -: SEL_W]),
    .sel      (req_sel),
    .addr_err (req_err)
  );

  // PSEL is one-hot (or zero), so masking ignores every unselected slave.
  assign sel_ready = |(PREADY & PSEL);
  assign sel_err   = |(PSLVERR_S & PSEL);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i]) sel_rdata = sel_rdata | PRDATA[i*DATA_W +: DATA_W];
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET || state != ACCESS) wait_cnt <= '0;
    else if (!sel_ready)           wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == ACCESS) && !sel_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign accept = transfer &&
                  ((state == IDLE) || ((state == ACCESS) && sel_ready && !timeout_hit));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state             <= IDLE;
      addr_err_q        <= 1'b0;
      PSEL              <= '0;
      PENABLE           <= 1'b0;
      PWRITE            <= 1'b0;
      PADDR             <= '0;
      PWDATA            <= '0;
      apb_read_data_out <= '0;
      PSLVERR           <= 1'b0;
      xfer_done         <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      PSLVERR   <= 1'b0;
      if (accept) begin
        PWRITE     <= ~READ_WRITE;
        PADDR      <= req_addr;
        PWDATA     <= apb_write_data;
        addr_err_q <= req_err;
      end
      case (state)
        IDLE: begin
          if (transfer) begin
            PSEL    <= req_sel;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (addr_err_q) begin
            xfer_done <= 1'b1;
            PSLVERR   <= 1'b1;
            PSEL      <= '0;
            state     <= IDLE;
          end else begin
            PENABLE <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (timeout_hit) begin
            xfer_done <= 1'b1;
            PSLVERR   <= 1'b1;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end else if (sel_ready) begin
            xfer_done <= 1'b1;
            PSLVERR   <= sel_err;
            PENABLE   <= 1'b0;
            if (!PWRITE && !sel_err) apb_read_data_out <= sel_rdata;
            if (transfer) begin
              PSEL  <= req_sel;
              state <= SETUP;
            end else begin
              PSEL  <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// tb/tb_apb_multi_slave_bridge.sv - directed scoreboard bench for the multi-slave APB bridge
module tb_apb_multi_slave_bridge;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic       PRESET;
  logic       rw;
  logic [8:0] waddr, raddr;
  logic [7:0] wdata;

  logic        trans_a, err_a, done_a, pen_a, pwr_a;
  logic [7:0]  rdata_a, pwdata_a;
  logic [1:0]  psel_a, pready_a, pslverr_s_a;
  logic [8:0]  paddr_a;
  logic [15:0] prdata_a;

  logic        trans_b, err_b, done_b, pen_b, pwr_b;
  logic [7:0]  rdata_b, pwdata_b;
  logic [2:0]  psel_b, pready_b, pslverr_s_b;
  logic [8:0]  paddr_b;
  logic [23:0] prdata_b;

  apb_multi_slave_bridge dut_a (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(trans_a), .READ_WRITE(rw),
    .apb_write_paddr(waddr), .apb_write_data(wdata), .apb_read_paddr(raddr),
    .apb_read_data_out(rdata_a), .PSLVERR(err_a), .xfer_done(done_a),
    .PSEL(psel_a), .PENABLE(pen_a), .PWRITE(pwr_a), .PADDR(paddr_a), .PWDATA(pwdata_a),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR_S(pslverr_s_a)
  );

  apb_multi_slave_bridge #(.NUM_SLV(3)) dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(trans_b), .READ_WRITE(rw),
    .apb_write_paddr(waddr), .apb_write_data(wdata), .apb_read_paddr(raddr),
    .apb_read_data_out(rdata_b), .PSLVERR(err_b), .xfer_done(done_b),
    .PSEL(psel_b), .PENABLE(pen_b), .PWRITE(pwr_b), .PADDR(paddr_b), .PWDATA(pwdata_b),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR_S(pslverr_s_b)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag, input bit on_b);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_pslverr"}, 32'(on_b ? err_b : err_a), 32'(e.err));
    check({tag, "_rdata"}, 32'(on_b ? rdata_b : rdata_a), 32'(e.rdata));
  endtask

  task automatic wait_done(input string tag, input bit on_b, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge PCLK);
      if (on_b ? done_b : done_a) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) pop_check(tag, on_b);
  endtask

  task automatic req(input bit on_b, input logic r, input logic [8:0] a, input logic [7:0] d,
                     input exp_t e);
    rw    = r;
    raddr = a;
    waddr = a;
    wdata = d;
    if (on_b) trans_b = 1'b1;
    else      trans_a = 1'b1;
    sb.push_back(e);
  endtask

  initial begin
    PRESET = 1'b1;
    rw = 1'b0; waddr = '0; raddr = '0; wdata = '0;
    trans_a = 1'b0; pready_a = '0; pslverr_s_a = '0; prdata_a = '0;
    trans_b = 1'b0; pready_b = '0; pslverr_s_b = '0; prdata_b = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_psel", 32'(psel_a), 0);
    check("rst_penable", 32'(pen_a), 0);
    check("rst_pwrite", 32'(pwr_a), 0);
    check("rst_paddr", 32'(paddr_a), 0);
    check("rst_pwdata", 32'(pwdata_a), 0);
    check("rst_rdata", 32'(rdata_a), 0);
    check("rst_pslverr", 32'(err_a), 0);
    check("rst_done", 32'(done_a), 0);
    PRESET = 1'b0;

    // 1: zero-wait write to slave 0
    pready_a = 2'b11;
    req(1'b0, 1'b0, 9'h005, 8'hA5, '{err: 1'b0, rdata: 8'h00});
    @(negedge PCLK);
    trans_a = 1'b0;
    check("t1_setup_psel", 32'(psel_a), 'h1);
    check("t1_setup_penable", 32'(pen_a), 0);
    check("t1_setup_pwrite", 32'(pwr_a), 1);
    check("t1_setup_paddr", 32'(paddr_a), 'h005);
    check("t1_setup_pwdata", 32'(pwdata_a), 'hA5);
    check("t1_setup_done", 32'(done_a), 0);
    @(negedge PCLK);
    check("t1_access_penable", 32'(pen_a), 1);
    check("t1_access_psel", 32'(psel_a), 'h1);
    check("t1_access_done", 32'(done_a), 0);
    @(negedge PCLK);
    check("t1_done", 32'(done_a), 1);
    check("t1_idle_psel", 32'(psel_a), 0);
    check("t1_idle_penable", 32'(pen_a), 0);
    pop_check("t1", 1'b0);

    // 2: read slave 1 with three wait states; slave 0 ready/error must be ignored
    pready_a = 2'b01;
    pslverr_s_a = 2'b01;
    prdata_a = {8'h3C, 8'h77};
    req(1'b0, 1'b1, 9'h10F, 8'h00, '{err: 1'b0, rdata: 8'h3C});
    @(negedge PCLK);
    trans_a = 1'b0;
    check("t2_setup_psel", 32'(psel_a), 'h2);
    check("t2_setup_pwrite", 32'(pwr_a), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("t2_wait_penable", 32'(pen_a), 1);
      check("t2_wait_done", 32'(done_a), 0);
      if (i == 3) pready_a = 2'b11;
    end
    @(negedge PCLK);
    check("t2_done", 32'(done_a), 1);
    pop_check("t2", 1'b0);
    pslverr_s_a = 2'b00;

    // 4: back-to-back write then read with transfer held
    prdata_a = {8'hC3, 8'h11};
    req(1'b0, 1'b0, 9'h001, 8'h5A, '{err: 1'b0, rdata: 8'h3C});
    @(negedge PCLK);
    check("t4_setup1_psel", 32'(psel_a), 'h1);
    rw = 1'b1;
    raddr = 9'h101;
    sb.push_back('{err: 1'b0, rdata: 8'hC3});
    @(negedge PCLK);
    check("t4_access1_penable", 32'(pen_a), 1);
    check("t4_access1_done", 32'(done_a), 0);
    @(negedge PCLK);
    check("t4_done1", 32'(done_a), 1);
    pop_check("t4a", 1'b0);
    check("t4_setup2_psel", 32'(psel_a), 'h2);
    check("t4_setup2_penable", 32'(pen_a), 0);
    check("t4_setup2_pwrite", 32'(pwr_a), 0);
    check("t4_setup2_paddr", 32'(paddr_a), 'h101);
    trans_a = 1'b0;
    @(negedge PCLK);
    check("t4_access2_done", 32'(done_a), 0);
    check("t4_access2_penable", 32'(pen_a), 1);
    @(negedge PCLK);
    check("t4_done2", 32'(done_a), 1);
    pop_check("t4b", 1'b0);

    // 5: slave error on a read keeps the previous read data
    pslverr_s_a = 2'b01;
    prdata_a = {8'h00, 8'hEE};
    req(1'b0, 1'b1, 9'h005, 8'h00, '{err: 1'b1, rdata: 8'hC3});
    @(negedge PCLK);
    trans_a = 1'b0;
    wait_done("t5", 1'b0, 6);
    pslverr_s_a = 2'b00;

    // 6: reset in the middle of ACCESS drops the transfer
    pready_a = 2'b00;
    rw = 1'b0; waddr = 9'h020; wdata = 8'h99; trans_a = 1'b1;
    @(negedge PCLK);
    trans_a = 1'b0;
    @(negedge PCLK);
    check("t6_in_access", 32'(pen_a), 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("t6_rst_psel", 32'(psel_a), 0);
    check("t6_rst_penable", 32'(pen_a), 0);
    check("t6_rst_paddr", 32'(paddr_a), 0);
    check("t6_rst_pwdata", 32'(pwdata_a), 0);
    check("t6_rst_rdata", 32'(rdata_a), 0);
    check("t6_rst_done", 32'(done_a), 0);
    PRESET = 1'b0;
    pready_a = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("t6_no_done", 32'(done_a), 0);
      check("t6_no_psel", 32'(psel_a), 0);
    end

    // 3: three-slave bridge, good read then unmapped index 3
    pready_b = 3'b111;
    prdata_b = {8'h00, 8'h42, 8'h00};
    req(1'b1, 1'b1, 9'h0A0, 8'h00, '{err: 1'b0, rdata: 8'h42});
    @(negedge PCLK);
    trans_b = 1'b0;
    check("t3_good_psel", 32'(psel_b), 'h2);
    wait_done("t3a", 1'b1, 6);
    req(1'b1, 1'b1, 9'h1C0, 8'h00, '{err: 1'b1, rdata: 8'h42});
    @(negedge PCLK);
    trans_b = 1'b0;
    check("t3_unmapped_psel", 32'(psel_b), 0);
    check("t3_unmapped_penable", 32'(pen_b), 0);
    check("t3_unmapped_early_done", 32'(done_b), 0);
    @(negedge PCLK);
    check("t3_unmapped_done", 32'(done_b), 1);
    pop_check("t3b", 1'b1);
    @(negedge PCLK);
    check("t3_idle_penable", 32'(pen_b), 0);
    check("t3_sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
